// File: rtl/mpic_pkg.sv
// Shared constants and FSM state type for the mpic dispatch initiator.
package mpic_pkg;

   localparam int unsigned MPIC_NUM_IRQ  = 5;
   localparam int unsigned MPIC_DATA_W   = 16;
   localparam logic [31:0] MPIC_PIC_ADDR = 32'h0000_0000;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      PICK,
      OFFER,
      WR,
      HOLD
   } mpic_state_e;

endpackage

// File: rtl/mpic_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 wins; any_o flags a non-empty request.
module mpic_prio_enc
   import mpic_pkg::*;
#(
   parameter int unsigned NUM_IRQ = MPIC_NUM_IRQ
) (
   input  logic [NUM_IRQ-1:0] req_i,
   output logic [3:0]         idx_o,
   output logic               any_o
);

   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (req_i[i] && !any_o) begin
            idx_o = i[3:0];
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mpic_dispatch_wbm.sv
// Wishbone initiator: reads mpic pending, offers the top-priority vector, writes a one-hot clear.
// Optional bus timeout with sticky err_o when MPIC_DISPATCH_TIMEOUT_EN is defined.
module mpic_dispatch_wbm
   import mpic_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] PIC_ADDR   = ADDR_WIDTH'(MPIC_PIC_ADDR),
   parameter int unsigned           NUM_IRQ    = MPIC_NUM_IRQ,
   parameter int unsigned           HOLDOFF    = 2,
   parameter int unsigned           TIMEOUT    = 15
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   irq_i,
   output logic [ADDR_WIDTH-1:0]  wb_adr_o,
   output logic [MPIC_DATA_W-1:0] wb_dat_o,
   input  logic [MPIC_DATA_W-1:0] wb_dat_i,
   output logic [1:0]             wb_sel_o,
   output logic                   wb_we_o,
   output logic                   wb_cyc_o,
   output logic                   wb_stb_o,
   input  logic                   wb_ack_i,
   output logic                   vec_valid_o,
   output logic [3:0]             vec_o,
   input  logic                   vec_ready_i,
   output logic                   err_o
);

   // One counter serves both the holdoff wait and the bus timeout.
   localparam int unsigned CMAX = (HOLDOFF > TIMEOUT) ? HOLDOFF : TIMEOUT;
   localparam int unsigned CW   = $clog2(CMAX + 2);

   mpic_state_e            state_q;
   logic [NUM_IRQ-1:0]     pend_q;
   logic [3:0]             vec_q;
   logic                   vv_q;
   logic                   cyc_q, stb_q, we_q;
   logic [1:0]             sel_q;
   logic [MPIC_DATA_W-1:0] dat_q;
   logic [ADDR_WIDTH-1:0]  adr_q;
   logic [CW-1:0]          cnt_q;
   logic [3:0]             pick_idx;
   logic                   pick_any;

   mpic_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
      .req_i (pend_q),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   if (NUM_IRQ < MPIC_DATA_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^wb_dat_i[MPIC_DATA_W-1:NUM_IRQ];
   end

`ifdef MPIC_DISPATCH_TIMEOUT_EN
   logic err_q;
   logic to_hit;
   assign to_hit = (32'(cnt_q) + 32'd1) >= TIMEOUT;
   assign err_o  = err_q;
`else
   assign err_o  = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         pend_q  <= '0;
         vec_q   <= '0;
         vv_q    <= 1'b0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         dat_q   <= '0;
         adr_q   <= '0;
         cnt_q   <= '0;
`ifdef MPIC_DISPATCH_TIMEOUT_EN
         err_q   <= 1'b0;
`endif
      end else begin
         adr_q <= PIC_ADDR;
         case (state_q)
            IDLE: begin
               if (irq_i) begin
                  state_q <= RD;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  we_q    <= 1'b0;
                  sel_q   <= 2'b11;
                  cnt_q   <= '0;
               end
            end
            RD: begin
               if (wb_ack_i) begin
                  pend_q  <= wb_dat_i[NUM_IRQ-1:0];
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  sel_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= (|wb_dat_i[NUM_IRQ-1:0]) ? PICK : HOLD;
               end
`ifdef MPIC_DISPATCH_TIMEOUT_EN
               else if (to_hit) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  sel_q   <= '0;
                  cnt_q   <= '0;
                  err_q   <= 1'b1;
                  state_q <= HOLD;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
               end
`endif
            end
            PICK: begin
               vec_q   <= pick_idx;
               vv_q    <= pick_any;
               state_q <= pick_any ? OFFER : HOLD;
            end
            OFFER: begin
               if (vec_ready_i) begin
                  vv_q    <= 1'b0;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  we_q    <= 1'b1;
                  sel_q   <= 2'b11;
                  dat_q   <= MPIC_DATA_W'(1) << vec_q;
                  cnt_q   <= '0;
                  state_q <= WR;
               end
            end
            WR: begin
               if (wb_ack_i) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  we_q    <= 1'b0;
                  sel_q   <= '0;
                  dat_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= HOLD;
               end
`ifdef MPIC_DISPATCH_TIMEOUT_EN
               else if (to_hit) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  we_q    <= 1'b0;
                  sel_q   <= '0;
                  dat_q   <= '0;
                  cnt_q   <= '0;
                  err_q   <= 1'b1;
                  state_q <= HOLD;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
               end
`endif
            end
            HOLD: begin
               if ((32'(cnt_q) + 32'd1) >= HOLDOFF) state_q <= IDLE;
               else                                 cnt_q   <= cnt_q + CW'(1);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign wb_adr_o    = adr_q;
   assign wb_dat_o    = dat_q;
   assign wb_sel_o    = sel_q;
   assign wb_we_o     = we_q;
   assign wb_cyc_o    = cyc_q;
   assign wb_stb_o    = stb_q;
   assign vec_valid_o = vv_q;
   assign vec_o       = vec_q;

endmodule

// File: tb/tb_mpic_dispatch_wbm.sv
// Bench for mpic_dispatch_wbm: mpic responder model, directed and randomized dispatch checks.
module tb_mpic_dispatch_wbm;

   localparam int unsigned NIRQ    = 5;
   localparam int unsigned HOLDOFF = 2;
   localparam int unsigned TIMEOUT = 15;
   localparam logic [31:0] PADDR   = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        irq_i;
   logic [31:0] wb_adr_o;
   logic [15:0] wb_dat_o;
   logic [15:0] wb_dat_i;
   logic [1:0]  wb_sel_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o;
   logic        vec_valid_o;
   logic [3:0]  vec_o;
   logic        vec_ready = 1'b0;
   logic        err_o;

   // mpic responder model: registered ack, pending latch, registered irq
   logic        ack_q     = 1'b0;
   logic        ack_en    = 1'b1;
   logic [4:0]  pend_reg  = '0;
   logic [4:0]  inject    = '0;
   logic        irq_q     = 1'b0;
   logic        irq_force = 1'b0;
   logic [10:0] junk_hi   = '0;

   int unsigned    n_cmp  = 0;
   int unsigned    n_bad  = 0;
   int unsigned    rd_cnt = 0;
   int unsigned    vq[$];
   logic [15:0]    wq[$];
   logic           vv_prev = 1'b0;

   always #5 clk = ~clk;

   assign irq_i    = irq_q | irq_force;
   assign wb_dat_i = {junk_hi, pend_reg};

   always @(posedge clk) begin
      ack_q <= ack_en && wb_cyc_o && wb_stb_o && !ack_q;
      if (ack_q && wb_cyc_o && wb_stb_o && wb_we_o) pend_reg <= (pend_reg & ~wb_dat_o[4:0]) | inject;
      else                                          pend_reg <= pend_reg | inject;
      irq_q <= |pend_reg;
   end

   mpic_dispatch_wbm #(
      .ADDR_WIDTH (32),
      .PIC_ADDR   (PADDR),
      .NUM_IRQ    (NIRQ),
      .HOLDOFF    (HOLDOFF),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .irq_i       (irq_i),
      .wb_adr_o    (wb_adr_o),
      .wb_dat_o    (wb_dat_o),
      .wb_dat_i    (wb_dat_i),
      .wb_sel_o    (wb_sel_o),
      .wb_we_o     (wb_we_o),
      .wb_cyc_o    (wb_cyc_o),
      .wb_stb_o    (wb_stb_o),
      .wb_ack_i    (ack_q),
      .vec_valid_o (vec_valid_o),
      .vec_o       (vec_o),
      .vec_ready_i (vec_ready),
      .err_o       (err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, check bus rules and log completed bus/vector events.
   task automatic tick();
      @(negedge clk);
      if (!rst) begin
         chk("stb_without_cyc", 32'(wb_stb_o & ~wb_cyc_o), 32'd0);
         chk("sel", 32'(wb_sel_o), wb_cyc_o ? 32'd3 : 32'd0);
         if (!wb_we_o) chk("dat_when_not_we", 32'(wb_dat_o), 32'd0);
         if (wb_cyc_o) chk("adr", wb_adr_o, PADDR);
         if (wb_cyc_o && wb_stb_o && ack_q) begin
            if (wb_we_o) wq.push_back(wb_dat_o);
            else         rd_cnt++;
         end
         if (vec_valid_o && !vv_prev) vq.push_back(32'(vec_o));
      end
      vv_prev = vec_valid_o;
   endtask

   task automatic clear_log();
      vq.delete();
      wq.delete();
      rd_cnt = 0;
   endtask

   task automatic inject_mask(input logic [4:0] m);
      inject = m;
      tick();
      inject = '0;
   endtask

   task automatic drain(input int unsigned max_cyc, input bit rnd_ready);
      int unsigned n = 0;
      int unsigned quiet = 0;
      while (quiet < 8 && n < max_cyc) begin
         if (rnd_ready) vec_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
         if (pend_reg == '0 && !irq_i && !wb_cyc_o && !vec_valid_o) quiet++;
         else                                                        quiet = 0;
      end
      chk("drain_bound", 32'(n < max_cyc), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cyc"}, 32'(wb_cyc_o), 0);
      chk({tag, "_stb"}, 32'(wb_stb_o), 0);
      chk({tag, "_we"},  32'(wb_we_o), 0);
      chk({tag, "_sel"}, 32'(wb_sel_o), 0);
      chk({tag, "_dat"}, 32'(wb_dat_o), 0);
      chk({tag, "_adr"}, wb_adr_o, 0);
      chk({tag, "_vv"},  32'(vec_valid_o), 0);
      chk({tag, "_vec"}, 32'(vec_o), 0);
      chk({tag, "_err"}, 32'(err_o), 0);
   endtask

   function automatic logic [31:0] qv(input int unsigned idx);
      return (idx < vq.size()) ? 32'(vq[idx]) : 32'hDEAD;
   endfunction

   function automatic logic [31:0] qw(input int unsigned idx);
      return (idx < wq.size()) ? 32'(wq[idx]) : 32'hDEAD;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      int unsigned gap;
      int unsigned k;
      logic [4:0]  m;

      // reset state
      repeat (3) tick();
      chk_all_zero("reset");
      rst = 1'b0;
      tick();

      // single source, latency and write phase
      vec_ready = 1'b1;
      clear_log();
      inject_mask(5'h04);
      n = 0;
      while (!irq_i && n < 10) begin tick(); n++; end
      n = 0;
      do begin tick(); n++; end while (!vec_valid_o && n < 20);
      chk("latency", n, 4);
      chk("single_vec", 32'(vec_o), 2);
      tick();
      chk("single_wr_cyc", 32'(wb_cyc_o & wb_stb_o), 1);
      chk("single_wr_we", 32'(wb_we_o), 1);
      chk("single_wr_dat", 32'(wb_dat_o), 32'h0004);
      chk("single_vv_drop", 32'(vec_valid_o), 0);
      drain(100, 1'b0);
      chk("single_nvec", vq.size(), 1);
      chk("single_clear", qw(0), 32'h0004);
      chk("single_nrd", rd_cnt, 1);

      // priority: two pending, lowest first, each via a fresh read
      clear_log();
      inject_mask(5'h12);
      drain(200, 1'b0);
      chk("prio_nvec", vq.size(), 2);
      chk("prio_v0", qv(0), 1);
      chk("prio_v1", qv(1), 4);
      chk("prio_w0", qw(0), 32'h0002);
      chk("prio_w1", qw(1), 32'h0010);
      chk("prio_nrd", rd_cnt, 2);

      // spurious: irq without pending bits, holdoff gap between reads
      clear_log();
      irq_force = 1'b1;
      n = 0;
      while (!wb_cyc_o && n < 10) begin tick(); n++; end
      n = 0;
      while (wb_cyc_o && n < 10) begin tick(); n++; end
      gap = 1;
      n = 0;
      while (n < 10) begin
         tick();
         n++;
         if (wb_cyc_o) break;
         gap++;
      end
      irq_force = 1'b0;
      chk("spur_gap", gap, HOLDOFF + 1);
      drain(100, 1'b0);
      chk("spur_nrd", rd_cnt, 2);
      chk("spur_nvec", vq.size(), 0);
      chk("spur_nwr", wq.size(), 0);

      // CPU stall: vector stable, bus idle; write right after accept
      clear_log();
      vec_ready = 1'b0;
      inject_mask(5'h08);
      n = 0;
      while (!vec_valid_o && n < 20) begin tick(); n++; end
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall_vv", 32'(vec_valid_o), 1);
         chk("stall_vec", 32'(vec_o), 3);
         chk("stall_cyc", 32'(wb_cyc_o), 0);
      end
      vec_ready = 1'b1;
      tick();
      chk("stall_wr_cyc", 32'(wb_cyc_o), 1);
      chk("stall_wr_we", 32'(wb_we_o), 1);
      chk("stall_wr_dat", 32'(wb_dat_o), 32'h0008);
      chk("stall_vv_drop", 32'(vec_valid_o), 0);
      drain(100, 1'b0);
      chk("stall_nwr", wq.size(), 1);

      // reset during the clear write
      clear_log();
      inject_mask(5'h01);
      n = 0;
      while (!(wb_cyc_o && wb_we_o) && n < 20) begin tick(); n++; end
      rst = 1'b1;
      tick();
      chk_all_zero("midwr_rst");
      rst = 1'b0;
      tick();
      chk("midwr_no_clear", 32'(pend_reg), 32'h01);
      drain(200, 1'b0);
      chk("midwr_nwr", wq.size(), 1);
      chk("midwr_w0", qw(0), 32'h0001);
      chk("midwr_nrd", rd_cnt, 2);
      chk("midwr_v_after", qv(1), 0);

      // randomized masks against a bitwise model, random CPU acceptance
      for (int it = 0; it < 12; it++) begin
         m = 5'($urandom_range(1, 31));
         junk_hi = 11'($urandom);
         clear_log();
         inject_mask(m);
         drain(600, 1'b1);
         k = 0;
         for (int unsigned b = 0; b < NIRQ; b++) begin
            if (m[b]) begin
               chk("rand_vec", qv(k), b);
               chk("rand_clr", qw(k), 32'(1) << b);
               k++;
            end
         end
         chk("rand_nvec", vq.size(), k);
         chk("rand_nwr", wq.size(), k);
         chk("rand_nrd", rd_cnt, k);
      end
      vec_ready = 1'b1;
      junk_hi = '0;

`ifdef MPIC_DISPATCH_TIMEOUT_EN
      // read with no ack: timeout, sticky error, then normal service
      clear_log();
      ack_en = 1'b0;
      inject_mask(5'h01);
      n = 0;
      while (!wb_cyc_o && n < 10) begin tick(); n++; end
      n = 0;
      while (wb_cyc_o && n < 40) begin n++; tick(); end
      chk("to_cyc_len", n, TIMEOUT);
      chk("to_err", 32'(err_o), 1);
      chk("to_no_vec", vq.size(), 0);
      ack_en = 1'b1;
      drain(200, 1'b0);
      chk("to_err_sticky", 32'(err_o), 1);
      chk("to_served", qw(0), 32'h0001);
      rst = 1'b1;
      tick();
      chk("to_err_rst", 32'(err_o), 0);
      rst = 1'b0;
      tick();
`else
      chk("err_off", 32'(err_o), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mpic_dispatch_wbm.md
Name: mpic_dispatch_wbm

Overview:
- Wishbone initiator that services the 5-source mpic interrupt controller on behalf of the CPU.
- On a pending irq it reads the mpic pending register and selects the highest-priority source.
- It presents a vector to the CPU, then writes a one-hot clear back to the mpic.
- Sits between the mpic (as a Wishbone responder) and the core's interrupt entry logic.

Parameters:
- ADDR_WIDTH, 32, width of wb_adr_o.
- PIC_ADDR, 32'h0000_0000, byte address of the mpic pending/clear register.
- NUM_IRQ, 5, number of sources (1..16); occupies low bits of the 16-bit data bus.
- HOLDOFF, 2, idle cycles after the clear write before irq_i is sampled again; covers the mpic's registered irq_o lag.
- TIMEOUT, 15, bus-cycle timeout in clocks; used only with the optional feature.

Ports:
- clk_i in 1: clock.
- rst_i in 1: synchronous active-high reset.
- irq_i in 1: aggregated irq from the mpic.
- wb_adr_o out ADDR_WIDTH: bus address, always PIC_ADDR.
- wb_dat_o out 16: write data, one-hot clear mask.
- wb_dat_i in 16: read data, pending bits.
- wb_sel_o out 2: byte selects, always 2'b11 while cyc.
- wb_we_o out 1: write enable.
- wb_cyc_o out 1: bus cycle.
- wb_stb_o out 1: strobe.
- wb_ack_i in 1: responder ack.
- vec_valid_o out 1: vector offered to the CPU.
- vec_o out 4: source index.
- vec_ready_i in 1: CPU accepts vector.
- err_o out 1: sticky bus-timeout flag.

Behaviour:
- Reset and output values:
  - Reset is synchronous and active-high on clk_i.
  - In reset, all outputs are 0: cyc, stb, we, sel, dat, adr, vec_valid, vec, err. FSM goes to IDLE.
  - Reset mid-cycle drops cyc/stb at the next edge; no clear write is issued.
- FSM states and transitions:
  - IDLE: if irq_i=1, go to RD and assert cyc=stb=1, we=0 from the next cycle.
  - RD: hold cyc/stb until wb_ack_i.
    - On ack, capture wb_dat_i[NUM_IRQ-1:0] into pend and drop cyc/stb the same edge, so they are low the following cycle.
    - pend==0 (spurious): go to HOLD.
    - Otherwise: go to PICK.
  - PICK (1 cycle): vec = lowest set index of pend (bit 0 highest priority); go to OFFER.
  - OFFER: vec_valid_o=1 with vec_o stable. When vec_valid_o & vec_ready_i, drop vec_valid next cycle and go to WR.
  - WR: cyc=stb=we=1, wb_dat_o = 1<<vec, all other bits 0. Hold until ack, drop cyc/stb/we on the ack edge, go to HOLD.
  - HOLD: count HOLDOFF cycles ignoring irq_i, then go to IDLE.
- Other sources:
  - Remaining pend bits are not served from the stale snapshot.
  - Each interrupt costs a fresh read, because the mpic may latch new sources meanwhile.
- Bus rules:
  - At most one outstanding access.
  - stb never asserted without cyc.
  - wb_ack_i outside RD/WR is ignored.
  - wb_dat_o = 0 whenever we=0.
- Boundary cases:
  - Multiple pend bits: serve lowest index; re-enter via irq_i for the rest.
  - vec_ready_i asserted while vec_valid_o=0: ignored.
  - vec_ready_i held high: OFFER lasts exactly 1 cycle.
  - irq_i deasserting during RD/OFFER/WR does not abort.
- Latency with the mpic's 1-cycle ack and vec_ready_i tied high:
  - irq_i rise to vec_valid_o: 4 clocks (IDLE→RD, ack, PICK, OFFER).

Optional Feature:
- Macro: MPIC_DISPATCH_TIMEOUT_EN.
- Defined:
  - A counter runs in RD and WR.
  - If TIMEOUT clocks elapse with no ack, drop cyc/stb/we, set err_o=1 (sticky until rst_i), and go to HOLD.
  - No vector is offered from a timed-out RD.
- Undefined:
  - No counter; RD/WR wait indefinitely.
  - err_o is constant 0.

Decomposition:
- Shared package mpic_pkg holds:
  - MPIC_NUM_IRQ, MPIC_DATA_W (16).
  - The default PIC_ADDR constant.
  - The FSM state typedef {IDLE, RD, PICK, OFFER, WR, HOLD}.
- Sub-module mpic_prio_enc: combinational lowest-set-bit encoder, NUM_IRQ in → 4-bit index plus any flag. Reused by future vectored CPU logic.

Test Plan:
- Single source: irq_i=1, responder returns 16'h0004 with 1-cycle ack → vec_o=2, vec_valid_o 4 clocks after irq_i; then write with wb_dat_o=16'h0004, we=1, sel=2'b11.
- Priority: pending 16'h0012 → vec_o=1 and clear 16'h0002. After HOLD, with irq_i still 1 and read 16'h0010 → vec_o=4, clear 16'h0010.
- Spurious: read returns 16'h0000 → no vec_valid_o, no write; back in IDLE after HOLDOFF=2 cycles.
- CPU stall: vec_ready_i low for 10 cycles → vec_valid_o and vec_o held stable, cyc_o=0 throughout; write issues 1 cycle after accept.
- Reset mid-WR: rst_i pulse while cyc=1 → all outputs 0 next edge, FSM in IDLE, no further ack consumed.
- Timeout (macro defined): no ack for 15 cycles in RD → cyc/stb drop, err_o=1 and stays 1 through later successful transactions until rst_i.
